gate_exerciser: RTL and testbench
=================================

GATE_EXERCISER -- requirements
Module: gate_exerciser

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter SETTLE_CYCLES, default 2, cycles each input vector is held before C is sampled; legal range 1..255, out-of-range SHALL be an elaboration error.
REQ-003 Parameter ERR_W, default 4, width of ERR_CNT.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST_N  in  1  asynchronous active-low reset.
REQ-006 START  in  1  run request; sampled only in IDLE.
REQ-007 OP_SEL  in  2  expected function: 00 OR, 01 AND, 10 XOR, 11 NOR.
REQ-008 A, B  out  1 each  stimulus to gate under test.
REQ-009 C  in  1  response from gate under test.
REQ-010 BUSY  out  1  high from DRIVE entry until DONE state exit.
REQ-011 DONE  out  1  one-cycle pulse at end of a pass.
REQ-012 PASS  out  1  level; set at DONE if ERR_CNT==0; cleared on run start.
REQ-013 ERR_CNT  out  ERR_W  saturating mismatch count.
REQ-014 FAIL_VEC  out  4  bit i set if vector i ({A,B}=i) mismatched.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, SAMPLE, DONE.
REQ-016 IDLE->DRIVE on an edge with START=1; that edge (edge 0) SHALL latch OP_SEL, clear ERR_CNT, FAIL_VEC, PASS, and set vector index to 0.
REQ-017 In DRIVE/SAMPLE, A SHALL equal index bit 1 and B index bit 0, registered; in IDLE/DONE, A=B=0.
REQ-018 DRIVE SHALL last exactly SETTLE_CYCLES cycles, then SAMPLE exactly 1 cycle.
REQ-019 In SAMPLE, C SHALL be compared to the latched function of A,B; on mismatch ERR_CNT increments (saturating at 2^ERR_W-1) and FAIL_VEC[index] sets.
REQ-020 After SAMPLE, index<3 -> DRIVE with index+1; index==3 -> DONE.
REQ-021 DONE state SHALL last 1 cycle beginning at edge 4*(SETTLE_CYCLES+1); DONE=1 and PASS updated there; then IDLE (or per REQ-026).
REQ-022 START while BUSY, and OP_SEL changes mid-run, SHALL be ignored.
REQ-023 A START held high across IDLE re-entry SHALL start a new run.

Reset
REQ-024 RST_N low SHALL immediately force IDLE, A=B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VEC=0, index=0, including mid-run; no partial results are retained.

Configuration
REQ-025 Macro GATE_EXERCISER_LOOP_EN SHALL select loop mode.
REQ-026 With it defined: DONE state with START=1 SHALL go to DRIVE index 0 without clearing ERR_CNT/FAIL_VEC (accumulating across passes), PASS re-evaluated each DONE; START=0 -> IDLE. Without it: DONE always -> IDLE; each run is exactly one pass.

Structure
REQ-027 Shared package gate_pkg SHALL hold OP_SEL encodings (OP_OR, OP_AND, OP_XOR, OP_NOR), the FSM state typedef, and vector-count constant 4.
REQ-028 Golden function SHALL be a combinational sub-module gate_ref (OP, A, B -> expected); all else in gate_exerciser.

Verification
REQ-029 SETTLE_CYCLES=2, OP_SEL=OR, C=A|B, START pulse -> A,B step 00,01,10,11 every 3 cycles; DONE at edge 12; ERR_CNT=0, FAIL_VEC=0000, PASS=1.
REQ-030 OP_SEL=OR, C stuck 0 -> ERR_CNT=3, FAIL_VEC=1110, PASS=0.
REQ-031 OP_SEL=XOR, C=A|B -> ERR_CNT=1, FAIL_VEC=1000, PASS=0; OP_SEL toggled to AND mid-run -> same result.
REQ-032 RST_N low during vector 2 -> A=B=0, BUSY=0, ERR_CNT=0 at once; second START pulse during BUSY of a new run -> no restart, DONE still at edge 12.
REQ-033 GATE_EXERCISER_LOOP_EN, ERR_W=3, OP_SEL=OR, C stuck 1, START held -> 1 error per pass; ERR_CNT 1..7 then holds 7 from pass 8; FAIL_VEC=0001; START dropped -> IDLE after next DONE.

Source files
------------

// File: rtl/gate_pkg.sv
// gate_pkg: shared encodings, FSM state type and vector count for the gate exerciser.
package gate_pkg;
   localparam logic [1:0] OP_OR  = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_NOR = 2'b11;
   localparam int NUM_VEC = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_SAMPLE, ST_DONE} state_t;
endpackage

// File: rtl/gate_exerciser_if.sv
// gate_exerciser_if: run control, gate stimulus/response and result signals of the exerciser.
interface gate_exerciser_if #(parameter int ERR_W = 4);
   logic             start;
   logic [1:0]       op_sel;
   logic             a;
   logic             b;
   logic             c;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [3:0]       fail_vec;
   modport master (output start, op_sel, c, input a, b, busy, done, pass, err_cnt, fail_vec);
   modport slave  (input start, op_sel, c, output a, b, busy, done, pass, err_cnt, fail_vec);
endinterface

// File: rtl/gate_ref.sv
// gate_ref: golden two-input gate selected by the op encoding.
module gate_ref
   import gate_pkg::*;
(
   input  logic [1:0] op_i,
   input  logic       a_i,
   input  logic       b_i,
   output logic       y_o
);
   always_comb y_o = op_i == OP_OR  ? (a_i | b_i) :
                     op_i == OP_AND ? (a_i & b_i) :
                     op_i == OP_XOR ? (a_i ^ b_i) : ~(a_i | b_i);
endmodule

// File: rtl/gate_exerciser.sv
// gate_exerciser: drives all four {A,B} vectors into a gate and checks C against the golden gate.
// Define GATE_EXERCISER_LOOP_EN to keep running passes (accumulating errors) while START stays high.
module gate_exerciser
   import gate_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int ERR_W         = 4
) (
   input  logic clk_i,
   input  logic rst_n_i,
   gate_exerciser_if.slave bus
);
   if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("SETTLE_CYCLES must be in 1..255");
   end
   localparam logic [ERR_W-1:0] ERR_MAX = '1;
   localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [1:0] IDX_LAST = 2'(NUM_VEC - 1);
   state_t               state_q, state_d;
   logic [1:0]           op_q, op_d;
   logic [1:0]           idx_q, idx_d;
   logic [7:0]           cnt_q, cnt_d;
   logic                 a_q, a_d, b_q, b_d;
   logic [ERR_W-1:0]     err_q, err_d;
   logic [NUM_VEC-1:0]   fail_q, fail_d;
   logic                 pass_q, pass_d;
   logic                 expect_c;
   gate_ref u_ref (.op_i(op_q), .a_i(a_q), .b_i(b_q), .y_o(expect_c));
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         op_q    <= OP_OR;
         idx_q   <= '0;
         cnt_q   <= '0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         err_q   <= '0;
         fail_q  <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         pass_q  <= pass_d;
      end
   end
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fail_d  = fail_q;
      pass_d  = pass_q;
      unique case (state_q)
         ST_IDLE: if (bus.start) begin
            state_d = ST_DRIVE;
            op_d    = bus.op_sel;
            idx_d   = '0;
            cnt_d   = '0;
            err_d   = '0;
            fail_d  = '0;
            pass_d  = 1'b0;
         end
         ST_DRIVE: begin
            state_d = cnt_q == CNT_LAST ? ST_SAMPLE : ST_DRIVE;
            cnt_d   = cnt_q + 8'd1;
         end
         ST_SAMPLE: begin
            if (bus.c != expect_c) begin
               err_d         = err_q == ERR_MAX ? err_q : err_q + 1'b1;
               fail_d[idx_q] = 1'b1;
            end
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
               state_d = ST_DONE;
               pass_d  = err_d == '0;
            end else begin
               state_d = ST_DRIVE;
               idx_d   = idx_q + 2'd1;
            end
         end
         ST_DONE: begin
`ifdef GATE_EXERCISER_LOOP_EN
            state_d = bus.start ? ST_DRIVE : ST_IDLE;
`else
            state_d = ST_IDLE;
`endif
            idx_d = '0;
            cnt_d = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end
   // Stimulus follows the next index only while a vector is being driven or sampled.
   always_comb a_d = (state_d == ST_DRIVE || state_d == ST_SAMPLE) ? idx_d[1] : 1'b0;
   always_comb b_d = (state_d == ST_DRIVE || state_d == ST_SAMPLE) ? idx_d[0] : 1'b0;
   assign bus.a        = a_q;
   assign bus.b        = b_q;
   assign bus.busy     = state_q != ST_IDLE;
   assign bus.done     = state_q == ST_DONE;
   assign bus.pass     = pass_q;
   assign bus.err_cnt  = err_q;
   assign bus.fail_vec = fail_q;
endmodule

// File: tb/tb_gate_exerciser.sv
// tb_gate_exerciser: table-driven runs plus reset, restart and loop-mode sequences.
module tb_gate_exerciser;
   import gate_pkg::*;
   localparam int S = 2;
`ifdef GATE_EXERCISER_LOOP_EN
   localparam int EW = 3;
`else
   localparam int EW = 4;
`endif
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cmode = 0;
   int   passed = 0;
   int   total = 0;
   gate_exerciser_if #(.ERR_W(EW)) bus ();
   gate_exerciser #(.SETTLE_CYCLES(S), .ERR_W(EW)) dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
   always #5 clk = ~clk;
   // Gate under test: 0 = OR gate, 1 = stuck at 0, 2 = stuck at 1.
   always_comb bus.c = cmode == 0 ? (bus.a | bus.b) : (cmode == 2);
   typedef struct {
      logic [1:0] op;
      int         cm;
      int         tog_k;
      int         rs_k;
      int         err;
      logic [3:0] fail;
      logic       pass;
   } vec_t;
   vec_t tbl [8];
   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", n, act, exp);
   endtask
   task automatic wait_done();
      int n = 0;
      while (!bus.done && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("done_wait", int'(bus.done), 1);
   endtask
   task automatic run(input vec_t v, input string tag);
      bit ok = 1'b1;
      int vi;
      @(negedge clk);
      bus.op_sel = v.op;
      cmode      = v.cm;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 4 * (S + 1); k++) begin
         vi = k / (S + 1);
         if ({bus.a, bus.b} != 2'(vi) || !bus.busy || bus.done || bus.pass) ok = 1'b0;
         if (k == v.tog_k) bus.op_sel = OP_AND;
         bus.start = (k == v.rs_k);
         @(negedge clk);
      end
      chk({tag, "_seq"}, int'(ok), 1);
      chk({tag, "_done"}, int'(bus.done), 1);
      chk({tag, "_ab_done"}, int'({bus.a, bus.b}), 0);
      chk({tag, "_err"}, int'(bus.err_cnt), v.err);
      chk({tag, "_fail"}, int'(bus.fail_vec), int'(v.fail));
      chk({tag, "_pass"}, int'(bus.pass), int'(v.pass));
      @(negedge clk);
      chk({tag, "_done_end"}, int'(bus.done), 0);
      chk({tag, "_busy_end"}, int'(bus.busy), 0);
   endtask
   initial begin
      tbl[0] = '{OP_OR,  0, -1, -1, 0, 4'b0000, 1'b1};
      tbl[1] = '{OP_OR,  1, -1, -1, 3, 4'b1110, 1'b0};
      tbl[2] = '{OP_XOR, 0, -1, -1, 1, 4'b1000, 1'b0};
      tbl[3] = '{OP_XOR, 0,  4, -1, 1, 4'b1000, 1'b0};
      tbl[4] = '{OP_AND, 0, -1, -1, 2, 4'b0110, 1'b0};
      tbl[5] = '{OP_NOR, 2, -1, -1, 3, 4'b1110, 1'b0};
      tbl[6] = '{OP_NOR, 0, -1, -1, 4, 4'b1111, 1'b0};
      tbl[7] = '{OP_OR,  0, -1,  5, 0, 4'b0000, 1'b1};
      bus.start  = 1'b0;
      bus.op_sel = OP_OR;
      #12;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_pass", int'(bus.pass), 0);
      chk("rst_err", int'(bus.err_cnt), 0);
      chk("rst_fail", int'(bus.fail_vec), 0);
      chk("rst_ab", int'({bus.a, bus.b}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));
      // Reset during vector 2 must drop everything at once.
      @(negedge clk);
      bus.op_sel = OP_OR;
      cmode      = 1;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (7) @(negedge clk);
      chk("mid_ab", int'({bus.a, bus.b}), 2);
      chk("mid_err", int'(bus.err_cnt), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_ab", int'({bus.a, bus.b}), 0);
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_err", int'(bus.err_cnt), 0);
      chk("arst_fail", int'(bus.fail_vec), 0);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef GATE_EXERCISER_LOOP_EN
      @(negedge clk);
      bus.op_sel = OP_OR;
      cmode      = 2;
      bus.start  = 1'b1;
      for (int p = 1; p <= 9; p++) begin
         wait_done();
         chk($sformatf("loop%0d_err", p), int'(bus.err_cnt), p < 7 ? p : 7);
         chk($sformatf("loop%0d_fail", p), int'(bus.fail_vec), 1);
         chk($sformatf("loop%0d_pass", p), int'(bus.pass), 0);
         if (p == 9) bus.start = 1'b0;
         @(negedge clk);
         chk($sformatf("loop%0d_busy", p), int'(bus.busy), p < 9 ? 1 : 0);
      end
`else
      // START held through DONE re-enters IDLE and then starts a fresh run.
      @(negedge clk);
      bus.op_sel = OP_OR;
      cmode      = 0;
      bus.start  = 1'b1;
      wait_done();
      chk("hold_pass", int'(bus.pass), 1);
      @(negedge clk);
      chk("hold_idle", int'(bus.busy), 0);
      @(negedge clk);
      chk("hold_restart", int'(bus.busy), 1);
      bus.start = 1'b0;
      cmode     = 1;
      wait_done();
      chk("hold_err", int'(bus.err_cnt), 3);
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
